// File: rtl/weight_unpacker.sv
// ============================================================================
// weight_unpacker : unpacks 32-bit packed weight words into eight nibble lanes
//                   through a small FIFO, counting words per tile.
// Optional feature macro: WEIGHT_UNPACKER_OUTLIER_CHECK_EN (sticky err flag)
// Revision: 1.0
// ============================================================================
`default_nettype none

module weight_unpacker #(
   parameter int DEPTH = 2,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_mod,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_outlier,
   input  logic [5:0]       in_addr,
   input  logic             stall,
   output logic [3:0]       weight_0,
   output logic [3:0]       weight_1,
   output logic [3:0]       weight_2,
   output logic [3:0]       weight_3,
   output logic [3:0]       weight_4,
   output logic [3:0]       weight_5,
   output logic [3:0]       weight_6,
   output logic [3:0]       weight_7,
   output logic             sel,
   output logic             mod,
   output logic [5:0]       addr,
   output logic             out_valid,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 32 + 1 + 6;
   localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]      OCC_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] count_q, count_d;
   logic             mod_q, mod_d;
   logic             done_q, done_d;

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic [EW-1:0]    mem_q [DEPTH];

   logic [31:0]      data_q, data_d;
   logic             sel_q, sel_d;
   logic [5:0]       addr_q, addr_d;
   logic             valid_q, valid_d;

   logic             fifo_empty;
   logic             fifo_full;
   logic             accept;
   logic             push;
   logic             pop;
   logic             bypass;
   logic [EW-1:0]    head;

   // Handshake and FIFO control; ready depends only on registered state.
   always_comb begin
      fifo_empty = (occ_q == '0);
      fifo_full  = (occ_q == OCC_FULL);
      in_ready   = (state_q == RUN) && (count_q < len_q) && !fifo_full;
      accept     = in_valid && in_ready;
      pop        = !stall && !fifo_empty;
      // Empty FIFO and no stall: the word goes straight to the output stage.
      bypass     = accept && !stall && fifo_empty;
      push       = accept && !bypass;
      head       = mem_q[rptr_q];
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      occ_d  = occ_q;
      if (push) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_ONE;
         2'b01:   occ_d = occ_q - OCC_ONE;
         default: occ_d = occ_q;
      endcase
   end

   always_comb begin
      data_d  = data_q;
      sel_d   = sel_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      if (!stall) begin
         if (!fifo_empty) begin
            data_d  = head[EW-1:7];
            sel_d   = head[6] & ~mod_q;
            addr_d  = head[5:0];
            valid_d = 1'b1;
         end else if (bypass) begin
            data_d  = in_data;
            sel_d   = in_outlier & ~mod_q;
            addr_d  = in_addr;
            valid_d = 1'b1;
         end else begin
            data_d  = '0;
            sel_d   = 1'b0;
            addr_d  = '0;
            valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      mod_d   = mod_q;
      count_d = count_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               len_d   = cfg_len;
               mod_d   = cfg_mod;
               count_d = '0;
               state_d = (cfg_len == '0) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (accept) begin
               count_d = count_q + LEN_ONE;
               if (count_d == len_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Output registers already hold the final word once the FIFO is empty.
            if (fifo_empty && !stall) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         count_q <= '0;
         mod_q   <= 1'b0;
         done_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         occ_q   <= '0;
         data_q  <= '0;
         sel_q   <= 1'b0;
         addr_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         count_q <= count_d;
         mod_q   <= mod_d;
         done_q  <= done_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         occ_q   <= occ_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
      end
   end

   // Storage is data-only; occupancy is what makes an entry meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= {in_data, in_outlier, in_addr};
      end
   end

`ifdef WEIGHT_UNPACKER_OUTLIER_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q;
      if ((state_q == IDLE) && start) begin
         err_d = 1'b0;
      end else if (accept && in_outlier && !mod_q && (in_addr[2:0] == in_addr[5:3])) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign weight_0  = data_q[3:0];
   assign weight_1  = data_q[7:4];
   assign weight_2  = data_q[11:8];
   assign weight_3  = data_q[15:12];
   assign weight_4  = data_q[19:16];
   assign weight_5  = data_q[23:20];
   assign weight_6  = data_q[27:24];
   assign weight_7  = data_q[31:28];
   assign sel       = sel_q;
   assign mod       = mod_q;
   assign addr      = addr_q;
   assign out_valid = valid_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_unpacker.sv
// ============================================================================
// tb_weight_unpacker : directed scoreboard bench for weight_unpacker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_weight_unpacker;

   localparam int LEN_W = 8;

`ifdef WEIGHT_UNPACKER_OUTLIER_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_mod;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             in_outlier;
   logic [5:0]       in_addr;
   logic             stall;
   logic [3:0]       weight_0, weight_1, weight_2, weight_3;
   logic [3:0]       weight_4, weight_5, weight_6, weight_7;
   logic             sel, mod, out_valid, busy, done, err;
   logic [5:0]       addr;

   weight_unpacker #(.DEPTH(2), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_mod(cfg_mod),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_outlier(in_outlier), .in_addr(in_addr), .stall(stall),
      .weight_0(weight_0), .weight_1(weight_1), .weight_2(weight_2), .weight_3(weight_3),
      .weight_4(weight_4), .weight_5(weight_5), .weight_6(weight_6), .weight_7(weight_7),
      .sel(sel), .mod(mod), .addr(addr), .out_valid(out_valid),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic        sel;
      logic [5:0]  addr;
      logic        mod;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_pop    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a new word is loaded only when the previous cycle was not stalled.
   logic        prev_stall = 1'b0;
   logic [47:0] prev_out   = '0;

   always @(negedge clk) begin
      logic [31:0] w_now;
      logic [47:0] o_now;
      exp_t        e;
      w_now = {weight_7, weight_6, weight_5, weight_4, weight_3, weight_2, weight_1, weight_0};
      o_now = {7'd0, out_valid, sel, mod, addr, w_now};
      if (prev_stall && !rst) begin
         chk("stall_hold", o_now, prev_out);
      end else if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", {32'd0, w_now}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            n_pop++;
            chk("sb_data", w_now, e.data);
            chk("sb_sel",  sel,   e.sel);
            chk("sb_addr", addr,  e.addr);
            chk("sb_mod",  mod,   e.mod);
         end
      end
      prev_stall = stall;
      prev_out   = o_now;
   end

   task automatic run_tile(input int len, input logic m, input logic [31:0] base,
                           input bit incr, input logic outl, input logic [5:0] ad,
                           input int ss, input int sl, input int stop_after,
                           output int done_cnt, output int done_iter, output int acc);
      exp_t e;
      start   = 1'b1;
      cfg_len = LEN_W'(len);
      cfg_mod = m;
      tick();
      start     = 1'b0;
      acc       = 0;
      done_cnt  = 0;
      done_iter = -1;
      for (int c = 0; c < 200; c++) begin
         if (done) begin
            done_cnt++;
            if (done_iter < 0) done_iter = c;
            chk("busy_low_with_done", busy, 0);
         end
         if (done_cnt > 0 && c > done_iter + 2) break;
         if (acc == stop_after) break;
         stall      = (c >= ss) && (c < ss + sl);
         in_valid   = (acc < len);
         in_data    = base + (incr ? 32'(acc) : 32'd0);
         in_outlier = outl;
         in_addr    = ad;
         if (len == 0 && c < 2) chk("zero_len_ready", in_ready, 0);
         if (sl > 0 && c == ss + 3) chk("ready_low_when_full", in_ready, 0);
         if (in_valid && in_ready) begin
            e.data = in_data;
            e.sel  = outl & ~m;
            e.addr = ad;
            e.mod  = m;
            exp_q.push_back(e);
            acc++;
         end
         tick();
      end
      in_valid = 1'b0;
      stall    = 1'b0;
   endtask

   initial begin
      int dc, di, acc, pops0;
      rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_mod = 1'b0;
      in_valid = 1'b0; in_data = '0; in_outlier = 1'b0; in_addr = '0; stall = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("reset_weights", {weight_7, weight_6, weight_5, weight_4,
                            weight_3, weight_2, weight_1, weight_0}, 0);
      chk("reset_ctrl", {in_ready, sel, mod, addr, out_valid, busy, done, err}, 0);

      // Back-to-back tile of four identical words.
      pops0 = n_pop;
      run_tile(4, 1'b0, 32'h76543210, 1'b0, 1'b0, 6'd0, 1000, 0, 1000, dc, di, acc);
      chk("t1_done_count", dc, 1);
      chk("t1_done_cycle", di, 5);
      chk("t1_accepted", acc, 4);
      chk("t1_words_out", n_pop - pops0, 4);
      chk("t1_sb_empty", exp_q.size(), 0);

      // Outlier passthrough, outliers enabled then disabled.
      run_tile(1, 1'b0, 32'hA5A5C3C3, 1'b0, 1'b1, 6'b101_011, 1000, 0, 1000, dc, di, acc);
      chk("t2_done_count", dc, 1);
      chk("t2_no_err", err, 0);
      run_tile(1, 1'b1, 32'h0F1E2D3C, 1'b0, 1'b1, 6'b101_011, 1000, 0, 1000, dc, di, acc);
      chk("t3_done_count", dc, 1);
      chk("t3_mod_held", mod, 1);
      chk("t3_sb_empty", exp_q.size(), 0);

      // Mid-tile stall with in_valid held high.
      run_tile(6, 1'b0, 32'h1000_0000, 1'b1, 1'b0, 6'd5, 2, 5, 1000, dc, di, acc);
      chk("t4_done_count", dc, 1);
      chk("t4_accepted", acc, 6);
      chk("t4_sb_empty", exp_q.size(), 0);

      // Zero-length tile.
      pops0 = n_pop;
      run_tile(0, 1'b0, 32'd0, 1'b0, 1'b0, 6'd0, 1000, 0, 1000, dc, di, acc);
      chk("t5_done_count", dc, 1);
      chk("t5_done_cycle", di, 1);
      chk("t5_no_words", n_pop - pops0, 0);

      // Reset after two of five words.
      run_tile(5, 1'b0, 32'h2000_0000, 1'b1, 1'b0, 6'd0, 1000, 0, 2, dc, di, acc);
      chk("t6_accepted", acc, 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      chk("t6_rst_weights", {weight_7, weight_6, weight_5, weight_4,
                             weight_3, weight_2, weight_1, weight_0}, 0);
      chk("t6_rst_ctrl", {in_ready, sel, mod, addr, out_valid, busy, done, err}, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t6_no_done", {done, busy}, 0);
      end
      run_tile(1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd7, 1000, 0, 1000, dc, di, acc);
      chk("t6_restart_done", dc, 1);
      chk("t6_sb_empty", exp_q.size(), 0);

      // Outlier slot equals lane: optional error flag.
      run_tile(1, 1'b0, 32'h13579BDF, 1'b0, 1'b1, 6'b010_010, 1000, 0, 1000, dc, di, acc);
      chk("t7_done_count", dc, 1);
      chk("t7_err_set", err, EXP_ERR);
      repeat (3) tick();
      chk("t7_err_sticky", err, EXP_ERR);
      start = 1'b1; cfg_len = '0; cfg_mod = 1'b0;
      tick();
      start = 1'b0;
      chk("t7_err_cleared", err, 0);
      repeat (4) tick();
      chk("t7_idle", busy, 0);
      chk("t7_sb_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
